// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between issue, the EX-stage ALU and writeback.
// The master drives operations and out_ready; the slave (ALU) returns results and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             oflow;
  logic             illegal;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, result, zero, oflow, illegal
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, result, zero, oflow, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus an optional
// iterative shift-add multiplier; result and flags are registered and held until consumed.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 oflow_q, oflow_d;
  logic                 illegal_q, illegal_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic                 hi_q, hi_d;

  logic                 in_ready, accept, is_mul, op_ill, alu_of;
  logic [WIDTH-1:0]     a, b, sum, diff, alu_res, mul_res;
  logic [SW-1:0]        shamt;
  logic [2*WIDTH-1:0]   acc_step;

  assign a        = bus.in1;
  assign b        = bus.in2;
  assign shamt    = b[SW-1:0];
  assign sum      = a + b;
  assign diff     = a - b;
  assign is_mul   = (MUL_EN != 0) && (bus.op == 4'd9 || bus.op == 4'd10);
  assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mul_res  = hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

  // Single-cycle datapath; illegal opcodes leave alu_res at 0.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    op_ill  = 1'b0;
    case (bus.op)
      4'd0:  alu_res = a & b;
      4'd1:  alu_res = a | b;
      4'd2: begin
        alu_res = sum;
        alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd4:  alu_res = a << shamt;
      4'd5:  alu_res = a >> shamt;
      4'd6: begin
        alu_res = diff;
        alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd8:  alu_res = WIDTH'($signed(a) >>> shamt);
      4'd9, 4'd10: op_ill = (MUL_EN == 0);
      4'd12: alu_res = ~(a | b);
      4'd13: alu_res = a ^ b;
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    oflow_d   = oflow_q;
    illegal_d = illegal_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = MUL;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            hi_d     = (bus.op == 4'd10);
          end else begin
            state_d   = DONE;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            oflow_d   = alu_of;
            illegal_d = op_ill;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      MUL: begin
        // One multiplier bit per cycle; the WIDTH-th step lands straight in the result.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d   = DONE;
          result_d  = mul_res;
          zero_d    = (mul_res == '0);
          oflow_d   = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      oflow_q   <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      hi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      oflow_q   <= oflow_d;
      illegal_q <= illegal_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.oflow     = oflow_q;
  assign bus.illegal   = illegal_q;
endmodule
